wb_ctrl_scheduler: RTL and testbench



---
 rtl/wb_ctrl_scheduler.sv | 154 +++++++++++++++
 tb/tb_wb_ctrl_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl_scheduler.sv
// White-balance control sequencer: applies host config at a frame boundary (coefs R/G/B,
// then mode) and issues calibration strobes after a programmable number of frames.
module wb_ctrl_scheduler #(
   parameter int PX_WIDTH    = 10,
   parameter int FRACT_WIDTH = 10,
   parameter int CAL_FRAMES  = 2,
   parameter int SOF_TIMEOUT = 0
) (
   input  logic                            clk_i,
   input  logic                            rst_n_i,
   input  logic                            sof_i,
   input  logic                            cfg_stb_i,
   input  logic [1:0]                      cfg_mode_i,
   input  logic [PX_WIDTH+FRACT_WIDTH-1:0] cfg_r_coef_i,
   input  logic [PX_WIDTH+FRACT_WIDTH-1:0] cfg_g_coef_i,
   input  logic [PX_WIDTH+FRACT_WIDTH-1:0] cfg_b_coef_i,
   input  logic                            cal_req_i,
   output logic                            busy_o,
   output logic                            cal_done_o,
   output logic                            timeout_o,
   output logic [1:0]                      mode_o,
   output logic [1:0]                      man_sel_o,
   output logic [PX_WIDTH+FRACT_WIDTH-1:0] man_coef_o,
   output logic                            man_lock_o,
   output logic                            cal_stb_o,
   output logic [2:0]                      dbg_state_o
);
   // Handshake: all control inputs are single-cycle pulses sampled only in IDLE;
   // pulses arriving while busy_o=1 are dropped, never queued.
   localparam int COEF_WIDTH = PX_WIDTH + FRACT_WIDTH;
   localparam int CF_W       = $clog2(CAL_FRAMES + 1);
   localparam int TO_W       = (SOF_TIMEOUT > 0) ? $clog2(SOF_TIMEOUT + 1) : 1;
   localparam bit TO_EN      = (SOF_TIMEOUT > 0);
   localparam logic [CF_W-1:0] CF_LAST = CF_W'(CAL_FRAMES - 1);
   localparam logic [CF_W-1:0] CF_MAX  = CF_W'(CAL_FRAMES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((SOF_TIMEOUT > 0) ? SOF_TIMEOUT - 1 : 0);
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(SOF_TIMEOUT);
   localparam logic [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1) << FRACT_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_SOF = 3'd1,
      S_LOAD_R   = 3'd2,
      S_LOAD_G   = 3'd3,
      S_LOAD_B   = 3'd4,
      S_CAL_WAIT = 3'd5,
      S_CAL_STB  = 3'd6
   } state_t;

   state_t                r_state, w_next;
   logic [1:0]            r_sh_mode;
   logic [COEF_WIDTH-1:0] r_sh_r, r_sh_g, r_sh_b;
   logic [CF_W-1:0]       r_frm_cnt;
   logic [TO_W-1:0]       r_to_cnt;
   logic                  r_busy, r_timeout, r_man_lock, r_cal_stb;
   logic [1:0]            r_mode, r_man_sel;
   logic [COEF_WIDTH-1:0] r_man_coef;
   logic                  w_cfg_acc, w_cal_acc, w_in_wait, w_to_hit;

   assign w_cfg_acc = (r_state == S_IDLE) && cfg_stb_i;
   assign w_cal_acc = (r_state == S_IDLE) && !cfg_stb_i && cal_req_i && (r_mode == 2'd3);
   assign w_in_wait = (r_state == S_WAIT_SOF) || (r_state == S_CAL_WAIT);
   // A sof_i in the same cycle as the last counted clock resets the wait, so it wins.
   assign w_to_hit  = TO_EN && w_in_wait && !sof_i && (r_to_cnt == TO_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_cfg_acc)      w_next = S_WAIT_SOF;
            else if (w_cal_acc) w_next = S_CAL_WAIT;
         end
         S_WAIT_SOF: if (sof_i || w_to_hit) w_next = S_LOAD_R;
         S_LOAD_R:   w_next = S_LOAD_G;
         S_LOAD_G:   w_next = S_LOAD_B;
         S_LOAD_B:   w_next = S_IDLE;
         S_CAL_WAIT: begin
            if (w_to_hit)                              w_next = S_IDLE;
            else if (sof_i && (r_frm_cnt == CF_LAST))  w_next = S_CAL_STB;
         end
         S_CAL_STB:  w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= S_IDLE;
         r_sh_mode  <= 2'd0;
         r_sh_r     <= COEF_ONE;
         r_sh_g     <= COEF_ONE;
         r_sh_b     <= COEF_ONE;
         r_frm_cnt  <= '0;
         r_to_cnt   <= '0;
         r_busy     <= 1'b0;
         r_timeout  <= 1'b0;
         r_man_lock <= 1'b0;
         r_cal_stb  <= 1'b0;
         r_mode     <= 2'd0;
         r_man_sel  <= 2'd0;
         r_man_coef <= '0;
      end else begin
         r_state    <= w_next;
         r_busy     <= (w_next != S_IDLE);
         r_man_lock <= (w_next == S_LOAD_R) || (w_next == S_LOAD_G) || (w_next == S_LOAD_B);
         r_cal_stb  <= (w_next == S_CAL_STB);

         if (w_next == S_LOAD_R) begin
            r_man_sel  <= 2'd0;
            r_man_coef <= r_sh_r;
         end else if (w_next == S_LOAD_G) begin
            r_man_sel  <= 2'd1;
            r_man_coef <= r_sh_g;
         end else if (w_next == S_LOAD_B) begin
            r_man_sel  <= 2'd2;
            r_man_coef <= r_sh_b;
         end

         // Mode changes only after all three coefficients have been written.
         if (r_state == S_LOAD_B) r_mode <= r_sh_mode;

         if (w_cfg_acc) begin
            r_sh_mode <= cfg_mode_i;
            r_sh_r    <= cfg_r_coef_i;
            r_sh_g    <= cfg_g_coef_i;
            r_sh_b    <= cfg_b_coef_i;
         end

         if (w_cfg_acc || w_cal_acc) r_timeout <= 1'b0;
         else if (w_to_hit)          r_timeout <= 1'b1;

         if (w_cfg_acc || w_cal_acc)   r_to_cnt <= '0;
         else if (w_in_wait) begin
            if (sof_i)                 r_to_cnt <= '0;
            else if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 1'b1;
         end

         if (w_cal_acc) r_frm_cnt <= '0;
         else if ((r_state == S_CAL_WAIT) && sof_i && (r_frm_cnt != CF_MAX))
            r_frm_cnt <= r_frm_cnt + 1'b1;
      end
   end

   assign busy_o      = r_busy;
   assign cal_done_o  = r_cal_stb;
   assign cal_stb_o   = r_cal_stb;
   assign timeout_o   = r_timeout;
   assign mode_o      = r_mode;
   assign man_sel_o   = r_man_sel;
   assign man_coef_o  = r_man_coef;
   assign man_lock_o  = r_man_lock;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wb_ctrl_scheduler.sv
// Bench for wb_ctrl_scheduler: one default instance and one with a 100-clock SOF timeout,
// both driven by the same stimulus; a selector chooses which one is observed.
module tb_wb_ctrl_scheduler;
   localparam int CW   = 20;
   localparam int CALF = 2;
   localparam int TO   = 100;

   logic          clk, rst_n, sof, cfg_stb, cal_req;
   logic [1:0]    cfg_mode;
   logic [CW-1:0] cfg_r, cfg_g, cfg_b;

   logic          d_busy, d_done, d_to, d_lock, d_stb;
   logic [1:0]    d_mode, d_sel;
   logic [CW-1:0] d_coef;
   logic [2:0]    d_dbg;
   logic          t_busy, t_done, t_to, t_lock, t_stb;
   logic [1:0]    t_mode, t_sel;
   logic [CW-1:0] t_coef;
   logic [2:0]    t_dbg;

   logic          sel_to;
   logic          o_busy, o_done, o_to, o_lock, o_stb;
   logic [1:0]    o_mode, o_sel;
   logic [CW-1:0] o_coef;

   int            checks, errors;
   logic [1:0]    m_mode;
   logic [CW+1:0] exp_q[$];

   wb_ctrl_scheduler #(.PX_WIDTH(10), .FRACT_WIDTH(10), .CAL_FRAMES(CALF), .SOF_TIMEOUT(0)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .sof_i(sof), .cfg_stb_i(cfg_stb), .cfg_mode_i(cfg_mode),
      .cfg_r_coef_i(cfg_r), .cfg_g_coef_i(cfg_g), .cfg_b_coef_i(cfg_b), .cal_req_i(cal_req),
      .busy_o(d_busy), .cal_done_o(d_done), .timeout_o(d_to), .mode_o(d_mode),
      .man_sel_o(d_sel), .man_coef_o(d_coef), .man_lock_o(d_lock), .cal_stb_o(d_stb),
      .dbg_state_o(d_dbg));

   wb_ctrl_scheduler #(.PX_WIDTH(10), .FRACT_WIDTH(10), .CAL_FRAMES(CALF), .SOF_TIMEOUT(TO)) dut_to (
      .clk_i(clk), .rst_n_i(rst_n), .sof_i(sof), .cfg_stb_i(cfg_stb), .cfg_mode_i(cfg_mode),
      .cfg_r_coef_i(cfg_r), .cfg_g_coef_i(cfg_g), .cfg_b_coef_i(cfg_b), .cal_req_i(cal_req),
      .busy_o(t_busy), .cal_done_o(t_done), .timeout_o(t_to), .mode_o(t_mode),
      .man_sel_o(t_sel), .man_coef_o(t_coef), .man_lock_o(t_lock), .cal_stb_o(t_stb),
      .dbg_state_o(t_dbg));

   assign o_busy = sel_to ? t_busy : d_busy;
   assign o_done = sel_to ? t_done : d_done;
   assign o_to   = sel_to ? t_to   : d_to;
   assign o_lock = sel_to ? t_lock : d_lock;
   assign o_stb  = sel_to ? t_stb  : d_stb;
   assign o_mode = sel_to ? t_mode : d_mode;
   assign o_sel  = sel_to ? t_sel  : d_sel;
   assign o_coef = sel_to ? t_coef : d_coef;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
      sof     = 1'b0;
      cfg_stb = 1'b0;
      cal_req = 1'b0;
   endtask

   function automatic logic [CW-1:0] rnd_coef;
      return CW'($urandom & 32'h000F_FFFF);
   endfunction

   task automatic do_reset;
      rst_n = 1'b0;
      tick;
      tick;
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      m_mode = 2'd0;
      exp_q.delete();
   endtask

   // Drive a cfg pulse in the current cycle t; returns in cycle t+1.
   task automatic issue_cfg(input logic [1:0] mode, input logic [CW-1:0] r, g, b,
                            input bit with_sof, input bit with_cal);
      cfg_stb  = 1'b1;
      cfg_mode = mode;
      cfg_r    = r;
      cfg_g    = g;
      cfg_b    = b;
      sof      = with_sof;
      cal_req  = with_cal;
      exp_q.push_back({2'd0, r});
      exp_q.push_back({2'd1, g});
      exp_q.push_back({2'd2, b});
      tick;
      checks++;
      if (o_busy !== 1'b1 || o_to !== 1'b0 || o_lock !== 1'b0) begin
         errors++;
         $display("FAIL cfg_accept got busy=%b timeout=%b lock=%b exp busy=1 timeout=0 lock=0",
                  o_busy, o_to, o_lock);
      end
   endtask

   // Called in the first cycle after the triggering frame start (or timeout).
   task automatic check_loads(input logic [1:0] new_mode);
      logic [CW+1:0] exp_v;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL load_%0d scoreboard empty", k);
         end else begin
            exp_v = exp_q.pop_front();
            if (o_lock !== 1'b1 || {o_sel, o_coef} !== exp_v || o_mode !== m_mode) begin
               errors++;
               $display("FAIL load_%0d got lock=%b sel=%0d coef=%h mode=%0d exp lock=1 sel=%0d coef=%h mode=%0d",
                        k, o_lock, o_sel, o_coef, o_mode, exp_v[CW+1:CW], exp_v[CW-1:0], m_mode);
            end
         end
         tick;
      end
      checks++;
      if (o_lock !== 1'b0 || o_busy !== 1'b0 || o_mode !== new_mode) begin
         errors++;
         $display("FAIL mode_update got lock=%b busy=%b mode=%0d exp lock=0 busy=0 mode=%0d",
                  o_lock, o_busy, o_mode, new_mode);
      end
      m_mode = new_mode;
   endtask

   // Full config sequence: frame start arrives gap cycles after the cfg pulse.
   task automatic run_cfg(input logic [1:0] mode, input logic [CW-1:0] r, g, b, input int gap,
                          input bit with_sof, input bit with_cal, input bit intrude);
      issue_cfg(mode, r, g, b, with_sof, with_cal);
      for (int i = 1; i < gap; i++) begin
         if (intrude && i == 1) begin
            cfg_stb  = 1'b1;
            cal_req  = 1'b1;
            cfg_mode = ~mode;
            cfg_r    = ~r;
            cfg_g    = ~g;
            cfg_b    = ~b;
         end
         checks++;
         if (o_lock !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_sof got lock=%b busy=%b exp lock=0 busy=1", o_lock, o_busy);
         end
         tick;
      end
      sof = 1'b1;
      tick;
      check_loads(mode);
   endtask

   // Calibration request in the current cycle; CALF frame starts with gaps in [lo,hi].
   task automatic run_cal(input int lo, input int hi, input bit intrude);
      int gap;
      cal_req = 1'b1;
      tick;
      checks++;
      if (o_busy !== 1'b1 || o_stb !== 1'b0 || o_to !== 1'b0) begin
         errors++;
         $display("FAIL cal_accept got busy=%b stb=%b timeout=%b exp busy=1 stb=0 timeout=0",
                  o_busy, o_stb, o_to);
      end
      for (int n = 0; n < CALF; n++) begin
         gap = $urandom_range(hi, lo);
         for (int i = 1; i < gap; i++) begin
            if (intrude && n == 0 && i == 1) begin
               cfg_stb  = 1'b1;
               cfg_mode = 2'd0;
            end
            checks++;
            if (o_stb !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
               errors++;
               $display("FAIL cal_wait got stb=%b done=%b busy=%b exp stb=0 done=0 busy=1",
                        o_stb, o_done, o_busy);
            end
            tick;
         end
         sof = 1'b1;
         tick;
      end
      checks++;
      if (o_stb !== 1'b1 || o_done !== 1'b1 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL cal_pulse got stb=%b done=%b busy=%b exp stb=1 done=1 busy=1",
                  o_stb, o_done, o_busy);
      end
      tick;
      checks++;
      if (o_stb !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0 || o_mode !== m_mode) begin
         errors++;
         $display("FAIL cal_end got stb=%b done=%b busy=%b mode=%0d exp stb=0 done=0 busy=0 mode=%0d",
                  o_stb, o_done, o_busy, o_mode, m_mode);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n = 1'b0;
      tick;
      checks++;
      if (d_mode !== 2'd0 || d_sel !== 2'd0 || d_coef !== '0 || d_lock !== 1'b0 ||
          d_stb !== 1'b0 || d_busy !== 1'b0 || d_done !== 1'b0 || d_to !== 1'b0 || d_dbg !== 3'd0) begin
         errors++;
         $display("FAIL reset_values got mode=%0d sel=%0d coef=%h lock=%b stb=%b busy=%b done=%b to=%b st=%0d exp all 0",
                  d_mode, d_sel, d_coef, d_lock, d_stb, d_busy, d_done, d_to, d_dbg);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      m_mode = 2'd0;
   endtask

   task automatic test_basic;
      run_cfg(2'd2, 20'h00477, 20'h00400, 20'h00527, 10, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 5; n++)
         run_cfg(2'($urandom_range(3, 0)), rnd_coef(), rnd_coef(), rnd_coef(),
                 $urandom_range(20, 1), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_sof_same_and_busy;
      for (int n = 0; n < 3; n++)
         run_cfg(2'($urandom_range(3, 0)), rnd_coef(), rnd_coef(), rnd_coef(),
                 $urandom_range(15, 2), 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_cal;
      run_cfg(2'd3, rnd_coef(), rnd_coef(), rnd_coef(), 4, 1'b0, 1'b0, 1'b0);
      run_cal(1, 12, 1'b1);
      run_cal(1, 12, 1'b0);
      run_cfg(2'd0, rnd_coef(), rnd_coef(), rnd_coef(), 3, 1'b0, 1'b0, 1'b0);
      cal_req = 1'b1;
      tick;
      for (int i = 0; i < 20; i++) begin
         if (i % 3 == 0) sof = 1'b1;
         checks++;
         if (o_busy !== 1'b0 || o_stb !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL cal_ignored got busy=%b stb=%b done=%b exp all 0", o_busy, o_stb, o_done);
         end
         tick;
      end
   endtask

   task automatic test_cfg_cal_collide;
      run_cfg(2'd3, rnd_coef(), rnd_coef(), rnd_coef(), 5, 1'b0, 1'b0, 1'b0);
      run_cfg(2'($urandom_range(2, 0)), rnd_coef(), rnd_coef(), rnd_coef(), 6, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3 * CALF + 4; i++) begin
         if (i % 2 == 0) sof = 1'b1;
         checks++;
         if (o_stb !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL collide_no_cal got stb=%b busy=%b exp stb=0 busy=0", o_stb, o_busy);
         end
         tick;
      end
   endtask

   task automatic test_reset_mid_seq;
      issue_cfg(2'd2, rnd_coef(), rnd_coef(), rnd_coef(), 1'b0, 1'b0);
      tick;
      sof = 1'b1;
      tick;
      tick;
      checks++;
      if (o_lock !== 1'b1 || o_sel !== 2'd1) begin
         errors++;
         $display("FAIL pre_reset_load_g got lock=%b sel=%0d exp lock=1 sel=1", o_lock, o_sel);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (d_mode !== 2'd0 || d_sel !== 2'd0 || d_coef !== '0 || d_lock !== 1'b0 ||
          d_stb !== 1'b0 || d_busy !== 1'b0 || d_done !== 1'b0 || d_to !== 1'b0 || d_dbg !== 3'd0) begin
         errors++;
         $display("FAIL async_reset got mode=%0d sel=%0d coef=%h lock=%b stb=%b busy=%b done=%b to=%b st=%0d exp all 0",
                  d_mode, d_sel, d_coef, d_lock, d_stb, d_busy, d_done, d_to, d_dbg);
      end
      exp_q.delete();
      m_mode = 2'd0;
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      run_cfg(2'($urandom_range(3, 1)), rnd_coef(), rnd_coef(), rnd_coef(),
              $urandom_range(8, 1), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_timeout;
      sel_to = 1'b1;
      do_reset;
      issue_cfg(2'd3, rnd_coef(), rnd_coef(), rnd_coef(), 1'b0, 1'b0);
      for (int i = 1; i <= TO; i++) begin
         checks++;
         if (o_lock !== 1'b0 || o_to !== 1'b0) begin
            errors++;
            $display("FAIL to_wait cycle %0d got lock=%b timeout=%b exp lock=0 timeout=0", i, o_lock, o_to);
         end
         tick;
      end
      checks++;
      if (o_to !== 1'b1) begin
         errors++;
         $display("FAIL to_set got timeout=%b exp 1", o_to);
      end
      check_loads(2'd3);
      checks++;
      if (o_to !== 1'b1) begin
         errors++;
         $display("FAIL to_sticky got timeout=%b exp 1", o_to);
      end
      cal_req = 1'b1;
      tick;
      checks++;
      if (o_busy !== 1'b1 || o_to !== 1'b0) begin
         errors++;
         $display("FAIL to_cal_accept got busy=%b timeout=%b exp busy=1 timeout=0", o_busy, o_to);
      end
      for (int i = 1; i < TO; i++) begin
         checks++;
         if (o_stb !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL to_cal_wait got stb=%b busy=%b exp stb=0 busy=1", o_stb, o_busy);
         end
         tick;
      end
      tick;
      checks++;
      if (o_busy !== 1'b0 || o_to !== 1'b1 || o_stb !== 1'b0 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL to_cal_abort got busy=%b timeout=%b stb=%b done=%b exp busy=0 timeout=1 stb=0 done=0",
                  o_busy, o_to, o_stb, o_done);
      end
      run_cfg(2'd3, rnd_coef(), rnd_coef(), rnd_coef(), 5, 1'b0, 1'b0, 1'b0);
      run_cal(60, 60, 1'b0);
      checks++;
      if (o_to !== 1'b0) begin
         errors++;
         $display("FAIL to_clear_on_sof got timeout=%b exp 0", o_to);
      end
   endtask

   // ---------------- main ----------------
   initial begin
      checks   = 0;
      errors   = 0;
      sel_to   = 1'b0;
      rst_n    = 1'b0;
      sof      = 1'b0;
      cfg_stb  = 1'b0;
      cal_req  = 1'b0;
      cfg_mode = 2'd0;
      cfg_r    = '0;
      cfg_g    = '0;
      cfg_b    = '0;
      m_mode   = 2'd0;
      test_reset;
      test_basic;
      test_sof_same_and_busy;
      test_cal;
      test_cfg_cal_collide;
      test_reset_mid_seq;
      test_timeout;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
